// File: rtl/obj_avoid_ctrl.sv
// Obstacle-avoidance controller: debounces the detector's object flags and sequences
// cruise / steer / pivot-turn / reverse commands for the motor stage.
module obj_avoid_ctrl #(
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned TURN_CYCLES    = 8,
  parameter int unsigned REVERSE_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       left_object,
  input  logic       right_object,
  input  logic       front_object,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic       steer_left,
  output logic       steer_right,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] boxed_cnt
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] REV_LOAD  = CW'(REVERSE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CRUISE  = 3'd1,
    TURN_L  = 3'd2,
    TURN_R  = 3'd3,
    REVERSE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d, cnt_f_q, cnt_f_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] boxed_q, boxed_d;
  logic          pref_q, pref_d;
  logic          fwd_q, fwd_d, rev_q, rev_d;
  logic          sl_q, sl_d, sr_q, sr_d, busy_q, busy_d;
  logic          dl, dr, df;
  state_e        pref_turn;

  // Saturating run-length counter; any low sample restarts the count.
  function automatic logic [CW-1:0] deb_next(input logic x, input logic [CW-1:0] c);
    if (!x)               return '0;
    else if (c == DB_MAX) return c;
    else                  return c + CW'(1);
  endfunction

  always_comb begin
    cnt_l_d = deb_next(left_object,  cnt_l_q);
    cnt_r_d = deb_next(right_object, cnt_r_q);
    cnt_f_d = deb_next(front_object, cnt_f_q);
  end

  assign dl = (cnt_l_q == DB_MAX);
  assign dr = (cnt_r_q == DB_MAX);
  assign df = (cnt_f_q == DB_MAX);
  assign pref_turn = pref_q ? TURN_L : TURN_R;

  // Next-state, manoeuvre timer, turn preference and boxed-in counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pref_d  = pref_q;
    boxed_d = boxed_q;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = CRUISE;
        CRUISE: begin
          if (df) begin
            if (dl && dr) begin
              state_d = REVERSE;
              timer_d = REV_LOAD;
              if (boxed_q != CNT_MAX) boxed_d = boxed_q + CW'(1);
            end else if (dl) begin
              state_d = TURN_R;
              timer_d = TURN_LOAD;
            end else if (dr) begin
              state_d = TURN_L;
              timer_d = TURN_LOAD;
            end else begin
              state_d = pref_turn;
              timer_d = TURN_LOAD;
              pref_d  = ~pref_q;
            end
          end
        end
        TURN_L, TURN_R: begin
          if (timer_q == '0) state_d = CRUISE;
          else               timer_d = timer_q - CW'(1);
        end
        REVERSE: begin
          if (timer_q == '0) begin
            state_d = pref_turn;
            timer_d = TURN_LOAD;
            pref_d  = ~pref_q;
          end else begin
            timer_d = timer_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    fwd_d  = (state_d == CRUISE);
    rev_d  = (state_d == REVERSE);
    sl_d   = (state_d == TURN_L) || ((state_d == CRUISE) && dr && !dl);
    sr_d   = (state_d == TURN_R) || ((state_d == CRUISE) && dl && !dr);
    busy_d = (state_d == TURN_L) || (state_d == TURN_R) || (state_d == REVERSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      cnt_f_q <= '0;
      timer_q <= '0;
      boxed_q <= '0;
      pref_q  <= 1'b0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_l_q <= cnt_l_d;
      cnt_r_q <= cnt_r_d;
      cnt_f_q <= cnt_f_d;
      timer_q <= timer_d;
      boxed_q <= boxed_d;
      pref_q  <= pref_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
    end
  end

  assign motor_fwd   = fwd_q;
  assign motor_rev   = rev_q;
  assign steer_left  = sl_q;
  assign steer_right = sr_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign boxed_cnt   = boxed_q;

endmodule

// File: tb/tb_obj_avoid_ctrl.sv
// Bench for obj_avoid_ctrl: directed scenarios plus random flag traffic, all checked
// each cycle against a run-length / remaining-cycles reference model.
module tb_obj_avoid_ctrl;

  localparam int DEB = 4;
  localparam int TC  = 8;
  localparam int RC  = 6;

  logic       clk = 1'b0;
  logic       reset, enable, left_object, right_object, front_object;
  logic       motor_fwd, motor_rev, steer_left, steer_right, busy;
  logic [2:0] state;
  logic [7:0] boxed_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: consecutive-high run lengths and the current manoeuvre.
  int run_l, run_r, run_f;
  int m_mode, m_rem, m_pref, m_boxed;
  bit m_dl, m_dr;

  always #5 clk = ~clk;

  obj_avoid_ctrl #(.DEBOUNCE(DEB), .TURN_CYCLES(TC), .REVERSE_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .left_object(left_object), .right_object(right_object), .front_object(front_object),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev),
    .steer_left(steer_left), .steer_right(steer_right),
    .busy(busy), .state(state), .boxed_cnt(boxed_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_manoeuvre(input int mode, input int len);
    m_mode = mode;
    m_rem  = len;
  endtask

  task automatic model_edge();
    bit dl, dr, df;
    dl = (run_l >= DEB);
    dr = (run_r >= DEB);
    df = (run_f >= DEB);
    if (reset) begin
      run_l = 0; run_r = 0; run_f = 0;
      m_mode = 0; m_rem = 0; m_pref = 0; m_boxed = 0;
      m_dl = 0; m_dr = 0;
      return;
    end
    run_l = left_object  ? run_l + 1 : 0;
    run_r = right_object ? run_r + 1 : 0;
    run_f = front_object ? run_f + 1 : 0;
    m_dl = dl;
    m_dr = dr;
    if (!enable) begin
      m_mode = 0;
      m_rem  = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (df) begin
             if (dl && dr) begin
               start_manoeuvre(4, RC);
               if (m_boxed < 255) m_boxed++;
             end else if (dl) start_manoeuvre(3, TC);
             else if (dr)     start_manoeuvre(2, TC);
             else begin
               start_manoeuvre(m_pref ? 2 : 3, TC);
               m_pref ^= 1;
             end
           end
        2, 3: if (m_rem == 1) m_mode = 1; else m_rem--;
        default: if (m_rem == 1) begin
             start_manoeuvre(m_pref ? 2 : 3, TC);
             m_pref ^= 1;
           end else m_rem--;
      endcase
    end
  endtask

  // One clock: advance the model at the edge, compare every output just after it.
  task automatic tick();
    bit e_sl, e_sr;
    @(posedge clk);
    model_edge();
    #1;
    e_sl = (m_mode == 2) || (m_mode == 1 && m_dr && !m_dl);
    e_sr = (m_mode == 3) || (m_mode == 1 && m_dl && !m_dr);
    chk("state",       8'(state),       8'(m_mode));
    chk("motor_fwd",   8'(motor_fwd),   8'(m_mode == 1));
    chk("motor_rev",   8'(motor_rev),   8'(m_mode == 4));
    chk("steer_left",  8'(steer_left),  8'(e_sl));
    chk("steer_right", 8'(steer_right), 8'(e_sr));
    chk("busy",        8'(busy),        8'(m_mode >= 2 && m_mode <= 4));
    chk("boxed_cnt",   boxed_cnt,       8'(m_boxed));
  endtask

  task automatic set_flags(input logic l, input logic r, input logic f);
    left_object  = l;
    right_object = r;
    front_object = f;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drop all flags and let any manoeuvre finish, bounded in cycles.
  task automatic settle();
    set_flags(0, 0, 0);
    for (int i = 0; i < 40 && !(m_mode == 1 && run_l == 0 && run_r == 0 && run_f == 0); i++)
      tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    set_flags(0, 0, 0);
    run_l = 0; run_r = 0; run_f = 0;
    m_mode = 0; m_rem = 0; m_pref = 0; m_boxed = 0; m_dl = 0; m_dr = 0;

    // Reset held, then enable
    ticks(10);
    chk("reset_state", 8'(state), 8'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    chk("enable_cruise", 8'(state), 8'd1);
    chk("enable_fwd", 8'(motor_fwd), 8'd1);
    chk("enable_boxed", boxed_cnt, 8'd0);

    // Short front glitch is rejected
    set_flags(0, 0, 1);
    ticks(3);
    set_flags(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_busy", 8'(busy), 8'd0);
      chk("glitch_state", 8'(state), 8'd1);
    end

    // Sustained front: TURN_R for exactly TC cycles, then second event turns left
    set_flags(0, 0, 1);
    ticks(4);
    chk("front_pre", 8'(state), 8'd1);
    tick();
    chk("front_turn_r", 8'(state), 8'd3);
    set_flags(0, 0, 0);
    for (int i = 1; i < TC; i++) begin
      tick();
      chk("turn_r_hold", 8'(state), 8'd3);
    end
    tick();
    chk("turn_r_done", 8'(state), 8'd1);
    set_flags(0, 0, 1);
    ticks(5);
    chk("front2_turn_l", 8'(state), 8'd2);
    settle();

    // Left side only: steer right while cruising
    set_flags(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("side_sr_pre", 8'(steer_right), 8'd0);
    end
    tick();
    chk("side_state", 8'(state), 8'd1);
    chk("side_sr", 8'(steer_right), 8'd1);
    chk("side_fwd", 8'(motor_fwd), 8'd1);
    chk("side_sl", 8'(steer_left), 8'd0);
    settle();

    // Boxed in: reverse, repeated until the counter saturates
    set_flags(1, 1, 1);
    ticks(5);
    chk("boxed_rev", 8'(state), 8'd4);
    chk("boxed_rev_out", 8'(motor_rev), 8'd1);
    chk("boxed_cnt1", boxed_cnt, 8'd1);
    ticks(300 * (RC + TC + 1));
    chk("boxed_sat", boxed_cnt, 8'd255);
    settle();

    // Front + one side: turn away from the side
    set_flags(1, 0, 1);
    ticks(5);
    chk("fl_turn_r", 8'(state), 8'd3);
    settle();
    set_flags(0, 1, 1);
    ticks(5);
    chk("fr_turn_l", 8'(state), 8'd2);
    settle();

    // enable drop during reverse cycle 3
    set_flags(1, 1, 1);
    ticks(5);
    ticks(2);
    enable = 1'b0;
    tick();
    chk("dis_state", 8'(state), 8'd0);
    chk("dis_outs", 8'({motor_fwd, motor_rev, steer_left, steer_right, busy}), 8'd0);
    set_flags(0, 0, 0);
    ticks(2);
    enable = 1'b1;
    tick();
    chk("reen_cruise", 8'(state), 8'd1);
    settle();

    // Reset pulse during TURN_L
    set_flags(0, 1, 1);
    ticks(5);
    chk("rst_turn_l", 8'(state), 8'd2);
    set_flags(0, 0, 0);
    ticks(2);
    reset = 1'b1;
    tick();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_boxed", boxed_cnt, 8'd0);
    reset = 1'b0;
    tick();
    set_flags(0, 0, 1);
    ticks(5);
    chk("rst_pref_r", 8'(state), 8'd3);
    settle();

    // Random flag traffic with occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) left_object  = ~left_object;
      if ($urandom_range(5, 0) == 0) right_object = ~right_object;
      if ($urandom_range(5, 0) == 0) front_object = ~front_object;
      if (enable) enable = ($urandom_range(49, 0) != 0);
      else        enable = ($urandom_range(2, 0) == 0);
      reset = ($urandom_range(299, 0) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obj_avoid_ctrl.md
Name: obj_avoid_ctrl

Overview:
- Consumer side of the object-detection flags: takes left_object / right_object / front_object from the detector FSM and issues drive/steer commands to the motor stage.
- Debounces each flag, then runs a Moore FSM that cruises, steers away from side objects, turns away from front objects and reverses when boxed in.
- Fixed-length manoeuvres are timed by a cycle counter.
- Sits between the detector and the motor driver.

Parameters:
- DEBOUNCE, 4, consecutive high samples before a flag counts as asserted (1..255)
- TURN_CYCLES, 8, clock cycles spent in a turn manoeuvre (1..255)
- REVERSE_CYCLES, 6, clock cycles spent reversing (1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = controller active; 0 = force IDLE
- left_object  input  1  object-left flag from detector
- right_object  input  1  object-right flag from detector
- front_object  input  1  object-front flag from detector
- motor_fwd  output  1  drive forward
- motor_rev  output  1  drive reverse
- steer_left  output  1  steer/turn left
- steer_right  output  1  steer/turn right
- busy  output  1  high in TURN_L, TURN_R or REVERSE
- state  output  3  current state code
- boxed_cnt  output  8  count of REVERSE entries, saturating at 255

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state = IDLE (0); all motor/steer outputs, busy and boxed_cnt = 0; all debounce counters and the timer = 0; turn preference pref = RIGHT (0).
- Debounce, per flag x:
  - A counter increments at each edge where x = 1, saturating at DEBOUNCE.
  - It clears to 0 at any edge where x = 0.
  - The debounced flag dx = (counter == DEBOUNCE).
  - The FSM samples dx, so it reacts at the (DEBOUNCE+1)-th edge after x first rises.
  - Outputs change at that same edge.
- State codes: IDLE = 0, CRUISE = 1, TURN_L = 2, TURN_R = 3, REVERSE = 4. Codes 5–7 are illegal and go to IDLE.
- Output decode (from the state register only):
  - IDLE: all outputs 0.
  - CRUISE: motor_fwd = 1; steer_right = dl & ~dr; steer_left = dr & ~dl. These steer terms use the registered debounced flags.
  - TURN_L: steer_left = 1 (pivot, motor_fwd = 0).
  - TURN_R: steer_right = 1 (pivot, motor_fwd = 0).
  - REVERSE: motor_rev = 1.
  - Mutual exclusion: motor_fwd and motor_rev are never both 1; steer_left and steer_right are never both 1.
- Transitions, evaluated each edge, with this priority:
  1. enable = 0 from any state -> IDLE; timer cleared. Debounce counters keep running.
  2. IDLE -> CRUISE when enable = 1.
  3. CRUISE, selected on (df, dl, dr):
     - df & dl & dr -> REVERSE; boxed_cnt increments (saturating).
     - df & dl & ~dr -> TURN_R.
     - df & dr & ~dl -> TURN_L.
     - df alone -> TURN_R if pref = 0, else TURN_L; pref toggles.
     - ~df -> stay in CRUISE.
  4. Turn timer: entering TURN_L or TURN_R loads the timer with TURN_CYCLES-1. The timer decrements each cycle. Leave to CRUISE at the edge where timer = 0, so the state lasts exactly TURN_CYCLES cycles. Flags are ignored during a turn.
  5. Reverse timer: entering REVERSE loads REVERSE_CYCLES-1. At timer = 0 go to TURN_R if pref = 0, else TURN_L; pref toggles. Flags are ignored.
- busy = 1 in TURN_L, TURN_R and REVERSE.
- Simultaneous events:
  - reset beats enable.
  - enable = 0 beats any timer expiry.
  - A flag dropping on the same edge its counter would saturate leaves the counter at 0.
- Reset mid-manoeuvre: next state IDLE, all counters 0, pref = 0, boxed_cnt = 0.

Test Plan:
1. Reset held 10 cycles, then enable = 1 -> state 0 during reset; state = 1 and motor_fwd = 1 one edge after enable; boxed_cnt = 0.
2. Glitch rejection: front_object high 3 cycles, then low -> state stays 1, busy never 1. Next, front_object high ≥4 cycles -> at the 5th edge state = 3 (TURN_R, first turn uses pref = 0) for exactly 8 cycles, then 1. A second front-only event -> state = 2 (pref alternated).
3. Side flag only: left_object held high -> after 5 edges state = 1, steer_right = 1, motor_fwd = 1; steer_left = 0 throughout.
4. Boxed in: L = R = F = 1 held -> state 4, motor_rev = 1 for 6 cycles, then TURN for 8 cycles, then CRUISE. boxed_cnt goes 0 -> 1, and re-enters REVERSE if the flags are still high. Run 300 events -> boxed_cnt = 255 (saturated).
5. Front plus left: F = L = 1 -> TURN_R. Front plus right: F = R = 1 -> TURN_L. pref unchanged in both cases.
6. Interrupts: enable = 0 during REVERSE cycle 3 -> state = 0 next edge, all outputs 0; re-enable -> CRUISE. Separately, reset pulsed 1 cycle during TURN_L -> state = 0, boxed_cnt = 0, the next front-only turn is TURN_R.
